bcd_down_timer: RTL and testbench
=================================

# bcd_down_timer

Multi-digit BCD countdown timer: the down-counting counterpart of the team's single-digit BCD up counter. Loads a BCD preset and decrements it by one on each qualified `tick` while running. It pulses `done` on reaching zero. It sits between the prescaler tick generator and the 7-segment display path, and feeds the alarm/control FSM.

## Interface
- `DIGITS`, default 4: number of BCD digits; count width is 4*DIGITS.
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `tick`  in  1: single-cycle count-enable pulse from the prescaler.
- `load`  in  1: capture `preset` and go to IDLE.
- `preset`  in  4*DIGITS: BCD preset; digit 0 is bits [3:0], least significant.
- `start`  in  1: begin or resume counting.
- `pause`  in  1: suspend counting.
- `count`  out  4*DIGITS: current BCD value, registered.
- `running`  out  1: high while in RUN.
- `done`  out  1: single-cycle pulse when terminal count is reached.
- `invalid`  out  1: sticky flag; last preset contained a digit > 9.

## Operation
- Stored preset register `preset_q` holds the clamped copy of the last loaded preset.
- FSM states and transitions:
  - **IDLE**
    - `start` with count != 0 → RUN.
    - `start` with count == 0 → ignored.
  - **RUN**
    - `pause` → PAUSED.
    - `tick` decrements.
    - Terminal tick → DONE (see below).
  - **PAUSED**
    - `start` without `pause` → RUN.
    - `tick` ignored.
  - **DONE**
    - count holds 0.
    - `start` → count <= preset_q, state RUN, provided preset_q != 0; otherwise stays DONE.
  - **Any state:** `load` → count <= clamped preset, preset_q <= clamped preset, state IDLE.
- Priority in one cycle, highest first: rst, load, pause, start, tick.
  - A tick coincident with `load`, `pause` or `start` is dropped.
- Load clamping and `invalid`:
  - Each preset digit > 9 is loaded as 9.
  - `invalid` is set if any digit was clamped, else cleared.
  - `invalid` updates only on `load`.
- Decrement is BCD with a borrow chain:
  - A digit > 0 decrements by 1 and stops the chain.
  - A digit == 0 becomes 9 and borrows from the next digit.
  - Digits are always 0–9; binary arithmetic never appears on `count`.
- Terminal tick is a `tick` in RUN with count == 1 (all upper digits 0, digit 0 == 1):
  - count <= 0, `done` pulses, state → DONE.

## Timing
- Reset values:
  - count = 0, preset_q = 0.
  - state IDLE.
  - `running` = 0, `done` = 0, `invalid` = 0.
- All outputs are registered.
- Control inputs are sampled on the rising edge; their effect is visible the following cycle.
- `tick` at edge N → decremented `count` valid after edge N, one-cycle latency.
- `running` rises the cycle after an accepted `start` and falls the cycle after `pause`, `load` or the terminal tick.
- `done` is high for exactly one cycle.
  - That cycle coincides with the first cycle count == 0, or the first cycle after reload under auto-reload.
  - `done` is never high for two consecutive cycles, even if `tick` is held high.
- Wrap example: DIGITS=4, count 1000 with tick → 0999 next cycle.
- `rst` mid-count clears immediately, asynchronously; no `done` is generated.
- `load` on the same edge as the terminal tick: load wins; no `done`; count = new preset.

## Configuration
- Macro: `BCD_TIMER_AUTO_RELOAD_EN`.
- Defined:
  - The terminal tick in RUN sets count <= preset_q and pulses `done`.
  - State stays RUN and `running` stays high; count never displays 0 during RUN.
  - DONE is reached only if preset_q == 0; that case behaves like undefined mode.
- Undefined: the terminal tick stops in DONE with count = 0, as described in Operation.

## Test plan
- Reset and load:
  - Assert `rst` mid-run → count=0, running=0, done=0 while rst is high.
  - Release rst, load 0x0000, start → stays IDLE, running=0.
- Borrow chain: load 0x1000, start, 1 tick → count=0x0999. Further 999 ticks → count=0x0000, one `done` pulse, state DONE.
- Clamping: load 0x0A5F → count=0x0959, invalid=1. Load 0x0012 → invalid=0.
- Priority:
  - In RUN, assert `tick`+`pause` together → count unchanged, running=0.
  - `start`+`tick` in PAUSED → running=1, count unchanged.
  - `load`+terminal tick together → count=new preset, done=0.
- Restart from DONE: preset 0x0003, run to 0, `start` → count=0x0003, running=1.
- With `BCD_TIMER_AUTO_RELOAD_EN`: preset 0x0002, tick held high 6 cycles → count sequence 2,1,2,1,2,1; done pulses on the cycles count returns to 2; running stays 1.

Source files
------------

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: loads a clamped BCD preset, counts down on tick, pulses done at zero.
// Optional feature macro: BCD_TIMER_AUTO_RELOAD_EN (terminal tick reloads preset_q and keeps running).
module bcd_down_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  invalid,
  output logic [1:0]            fsm_state
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Control handshake: load/start/pause/tick are level-sampled on each rising
  // edge with priority load > pause > start > tick; there is no back-pressure.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic [W-1:0]  preset_q;
  logic [W-1:0]  clamped;
  logic          any_clamped;
  logic [W-1:0]  decremented;
  logic          borrow;

  always_comb begin
    clamped     = '0;
    any_clamped = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (preset[4*i +: 4] > 4'd9) begin
        clamped[4*i +: 4] = 4'd9;
        any_clamped       = 1'b1;
      end else begin
        clamped[4*i +: 4] = preset[4*i +: 4];
      end
    end
  end

  // Ripple borrow: zero digits wrap to 9 until the first non-zero digit absorbs it.
  always_comb begin
    decremented = count;
    borrow      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          decremented[4*i +: 4] = 4'd9;
        end else begin
          decremented[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow                = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      preset_q <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count    <= clamped;
        preset_q <= clamped;
        invalid  <= any_clamped;
        state    <= IDLE;
        running  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!pause && start && count != '0) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (!start && tick) begin
              if (count == ONE) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                if (preset_q != '0) begin
                  // A reload while done is still high is held off so done never stretches.
                  if (!done) begin
                    count <= preset_q;
                    done  <= 1'b1;
                  end
                end else begin
                  count   <= '0;
                  done    <= 1'b1;
                  state   <= DONE;
                  running <= 1'b0;
                end
`else
                count   <= '0;
                done    <= 1'b1;
                state   <= DONE;
                running <= 1'b0;
`endif
              end else begin
                count <= decremented;
              end
            end
          end
          PAUSED: begin
            if (!pause && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: begin
            if (!pause && start && preset_q != '0) begin
              count   <= preset_q;
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed scenarios plus random traffic against a decimal-valued model.
// Honours BCD_TIMER_AUTO_RELOAD_EN when defined at compile time.
module tb_bcd_down_timer;

  logic        clk, rst, tick, load, start, pause;
  logic [15:0] preset;
  logic [15:0] count;
  logic        running, done, invalid;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;

  // Model: count and preset as plain decimal integers.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_cnt, m_pre, m_state;
  bit m_run, m_done, m_inv;

  bcd_down_timer #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .preset(preset),
    .start(start), .pause(pause), .count(count), .running(running),
    .done(done), .invalid(invalid), .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_state = M_IDLE;
    m_run = 0; m_done = 0; m_inv = 0;
  endtask

  task automatic model_update(input logic t, input logic l, input logic [15:0] p,
                              input logic s, input logic pa);
    bit prev_done;
    int d;
    prev_done = m_done;
    m_done = 0;
    if (l) begin
      m_pre = 0; m_inv = 0;
      for (int i = 0; i < 4; i++) begin
        d = int'(p[4*i +: 4]);
        if (d > 9) begin d = 9; m_inv = 1; end
        m_pre += d * (10 ** i);
      end
      m_cnt = m_pre; m_state = M_IDLE; m_run = 0;
    end else if (m_state == M_RUN) begin
      if (pa) begin
        m_state = M_PAUSED; m_run = 0;
      end else if (!s && t) begin
        if (m_cnt == 1) begin
`ifdef BCD_TIMER_AUTO_RELOAD_EN
          if (m_pre != 0) begin
            if (!prev_done) begin m_cnt = m_pre; m_done = 1; end
          end else begin
            m_cnt = 0; m_done = 1; m_state = M_DONE; m_run = 0;
          end
`else
          m_cnt = 0; m_done = 1; m_state = M_DONE; m_run = 0;
`endif
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end else if (!pa && s) begin
      if (m_state == M_IDLE && m_cnt != 0) begin
        m_state = M_RUN; m_run = 1;
      end else if (m_state == M_PAUSED) begin
        m_state = M_RUN; m_run = 1;
      end else if (m_state == M_DONE && m_pre != 0) begin
        m_cnt = m_pre; m_state = M_RUN; m_run = 1;
      end
    end
  endtask

  // Drive one cycle on the falling edge, advance the model at the rising edge, settle #1.
  task automatic step(input logic t, input logic l, input logic [15:0] p,
                      input logic s, input logic pa);
    @(negedge clk);
    tick = t; load = l; preset = p; start = s; pause = pa;
    @(posedge clk);
    model_update(t, l, p, s, pa);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 0; load = 0; preset = '0; start = 0; pause = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({count, running, done, invalid, fsm_state} !== {16'h0000, 3'b000, 2'd0}) begin
      $display("FAIL reset_values: got count=%h run=%b done=%b inv=%b st=%0d, want 0000 0 0 0 0",
               count, running, done, invalid, fsm_state);
      miscompares++;
    end
    @(negedge clk); rst = 1'b0;
    step(0, 1, 16'h1234, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    repeat (3) step(1, 0, 16'h0, 0, 0);
    vectors++;
    if (count !== 16'h1231 || running !== 1'b1) begin
      $display("FAIL pre_reset_run: got count=%h run=%b, want 1231 1", count, running);
      miscompares++;
    end
    @(negedge clk); #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if ({count, running, done} !== {16'h0000, 2'b00}) begin
      $display("FAIL async_reset: got count=%h run=%b done=%b, want 0000 0 0", count, running, done);
      miscompares++;
    end
    @(posedge clk); #1;
    vectors++;
    if ({count, running, done} !== {16'h0000, 2'b00}) begin
      $display("FAIL reset_held: got count=%h run=%b done=%b, want 0000 0 0", count, running, done);
      miscompares++;
    end
    @(negedge clk); rst = 1'b0; tick = 0;
    step(0, 1, 16'h0000, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 0);
    vectors++;
    if (running !== 1'b0 || count !== 16'h0000 || fsm_state !== 2'd0) begin
      $display("FAIL zero_start: got run=%b count=%h st=%0d, want 0 0000 0", running, count, fsm_state);
      miscompares++;
    end
  endtask

  task automatic test_borrow();
    int pulses;
    step(0, 1, 16'h1000, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 0);
    vectors++;
    if (count !== 16'h0999) begin
      $display("FAIL borrow_wrap: got count=%h, want 0999", count);
      miscompares++;
    end
    pulses = 0;
    for (int i = 0; i < 999; i++) begin
      step(1, 0, 16'h0, 0, 0);
      if (done) pulses++;
      vectors++;
      if ({count, running, done} !== {to_bcd(m_cnt), m_run, m_done}) begin
        $display("FAIL borrow_seq[%0d]: got count=%h run=%b done=%b, want %h %b %b",
                 i, count, running, done, to_bcd(m_cnt), m_run, m_done);
        miscompares++;
      end
    end
    step(1, 0, 16'h0, 0, 0);
    if (done) pulses++;
    vectors++;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    if (pulses !== 1 || count !== 16'h0999 || running !== 1'b1) begin
      $display("FAIL borrow_end: got pulses=%0d count=%h run=%b, want 1 0999 1", pulses, count, running);
      miscompares++;
    end
`else
    if (pulses !== 1 || count !== 16'h0000 || running !== 1'b0 || fsm_state !== 2'd3) begin
      $display("FAIL borrow_end: got pulses=%0d count=%h run=%b st=%0d, want 1 0000 0 3",
               pulses, count, running, fsm_state);
      miscompares++;
    end
`endif
  endtask

  task automatic test_clamp();
    step(0, 1, 16'h0A5F, 0, 0);
    vectors++;
    if (count !== 16'h0959 || invalid !== 1'b1) begin
      $display("FAIL clamp_high: got count=%h inv=%b, want 0959 1", count, invalid);
      miscompares++;
    end
    step(0, 0, 16'hFFFF, 1, 0);
    vectors++;
    if (invalid !== 1'b1) begin
      $display("FAIL invalid_sticky: got inv=%b, want 1", invalid);
      miscompares++;
    end
    step(0, 1, 16'h0012, 0, 0);
    vectors++;
    if (count !== 16'h0012 || invalid !== 1'b0) begin
      $display("FAIL clamp_clear: got count=%h inv=%b, want 0012 0", count, invalid);
      miscompares++;
    end
  endtask

  task automatic test_priority();
    step(0, 1, 16'h0050, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 1);
    vectors++;
    if (count !== 16'h0048 || running !== 1'b0) begin
      $display("FAIL tick_pause: got count=%h run=%b, want 0048 0", count, running);
      miscompares++;
    end
    step(1, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    vectors++;
    if (count !== 16'h0048 || running !== 1'b1) begin
      $display("FAIL start_tick_paused: got count=%h run=%b, want 0048 1", count, running);
      miscompares++;
    end
    step(0, 1, 16'h0002, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 0);
    step(1, 1, 16'h0007, 0, 0);
    vectors++;
    if (count !== 16'h0007 || done !== 1'b0 || running !== 1'b0) begin
      $display("FAIL load_terminal: got count=%h done=%b run=%b, want 0007 0 0", count, done, running);
      miscompares++;
    end
  endtask

  task automatic test_restart();
    step(0, 1, 16'h0003, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    repeat (3) step(1, 0, 16'h0, 0, 0);
    vectors++;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    if (count !== 16'h0003 || done !== 1'b1 || running !== 1'b1) begin
      $display("FAIL restart_terminal: got count=%h done=%b run=%b, want 0003 1 1", count, done, running);
      miscompares++;
    end
`else
    if (count !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin
      $display("FAIL restart_terminal: got count=%h done=%b run=%b, want 0000 1 0", count, done, running);
      miscompares++;
    end
    step(1, 0, 16'h0, 0, 0);
    vectors++;
    if (count !== 16'h0000 || done !== 1'b0) begin
      $display("FAIL done_hold: got count=%h done=%b, want 0000 0", count, done);
      miscompares++;
    end
    step(0, 0, 16'h0, 1, 0);
    vectors++;
    if (count !== 16'h0003 || running !== 1'b1) begin
      $display("FAIL restart_done: got count=%h run=%b, want 0003 1", count, running);
      miscompares++;
    end
`endif
  endtask

  task automatic test_tick_held();
    logic [15:0] exp_q[$];
    logic [15:0] want;
    bit want_done;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    exp_q = '{16'h0001, 16'h0002, 16'h0001, 16'h0002, 16'h0001, 16'h0002};
`else
    exp_q = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    step(0, 1, 16'h0002, 0, 0);
    step(0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 16'h0, 0, 0);
      want = exp_q.pop_front();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      want_done = (i % 2 == 1);
`else
      want_done = (i == 1);
`endif
      vectors++;
      if (count !== want || done !== want_done || running !== m_run) begin
        $display("FAIL tick_held[%0d]: got count=%h done=%b run=%b, want %h %b %b",
                 i, count, done, running, want, want_done, m_run);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] p;
    logic t, l, s, pa;
    logic prev_done;
    prev_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      l  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 9) == 0);
      pa = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0)
        p = 16'($urandom);
      else
        p = {4'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      step(t, l, p, s, pa);
      vectors++;
      if ({count, running, done, invalid} !== {to_bcd(m_cnt), m_run, m_done, m_inv} ||
          (done && prev_done)) begin
        $display("FAIL random[%0d]: got count=%h run=%b done=%b inv=%b, want %h %b %b %b",
                 i, count, running, done, invalid, to_bcd(m_cnt), m_run, m_done, m_inv);
        miscompares++;
      end
      prev_done = done;
    end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_clamp();
    test_priority();
    test_restart();
    test_tick_held();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
